// File: rtl/fc_layer_pkg.sv
// Shared types and helpers for fully-connected layer controllers.
//   seq_state_t : feed / wait / drain schedule states
//   IDX_W(n)    : index width for n entries, never less than 1 bit
package fc_layer_pkg;

  typedef enum logic [1:0] {IDLE, FEED, WAIT, DRAIN} seq_state_t;

  function automatic int unsigned IDX_W(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_result_bank.sv
// Capture registers for per-neuron results.
//   clk, rst  : clock, asynchronous active-high reset
//   we        : per-entry write enable (one bit per neuron)
//   wdata     : concatenated neuron outputs, entry k at [k*dataWidth +: dataWidth]
//   clr       : clear the capture mask (takes precedence over we)
//   rd_en     : load the read register from entry rd_idx
//   rd_idx    : read index
//   rd_data   : registered read data
//   all_done  : every entry captured, counting writes in the current cycle
module fc_result_bank
  import fc_layer_pkg::*;
#(
  parameter int unsigned numNeurons = 30,
  parameter int unsigned dataWidth  = 16,
  localparam int unsigned IdxW      = IDX_W(numNeurons)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [numNeurons-1:0]           we,
  input  logic [numNeurons*dataWidth-1:0] wdata,
  input  logic                            clr,
  input  logic                            rd_en,
  input  logic [IdxW-1:0]                 rd_idx,
  output logic [dataWidth-1:0]            rd_data,
  output logic                            all_done
);

  logic [dataWidth-1:0]  cap_q [numNeurons];
  logic [dataWidth-1:0]  cap_d [numNeurons];
  logic [numNeurons-1:0] mask_q, mask_d;
  logic [dataWidth-1:0]  rd_q, rd_d;

  always_comb begin
    for (int k = 0; k < numNeurons; k++) begin
      cap_d[k] = we[k] ? wdata[k*dataWidth +: dataWidth] : cap_q[k];
    end
    mask_d = clr ? '0 : (mask_q | we);
    rd_d   = rd_q;
    // Read from the write-forwarded value so the first drain element is
    // available in the cycle right after the final capture.
    if (rd_en) begin
      rd_d = '0;
      for (int k = 0; k < numNeurons; k++) begin
        if (rd_idx == IdxW'(k)) rd_d = cap_d[k];
      end
    end
  end

  assign all_done = &(mask_q | we);
  assign rd_data  = rd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < numNeurons; k++) cap_q[k] <= '0;
      mask_q <= '0;
      rd_q   <= '0;
    end else begin
      cap_q  <= cap_d;
      mask_q <= mask_d;
      rd_q   <= rd_d;
    end
  end

endmodule

// File: rtl/fc_layer_seq.sv
// Feed / wait / drain sequencer for one fully-connected layer.
//   clk, rst       : clock, asynchronous active-high reset
//   in_data/valid  : input elements from previous stage; in_ready accepts
//   nrn_in/_valid  : registered broadcast to every neuron
//   nrn_out/_valid : per-neuron results and their valid pulses
//   out_data/valid : drained results to next stage; out_ready accepts
//   busy           : not idle
//   err            : one-cycle pulse when the wait for results times out
module fc_layer_seq
  import fc_layer_pkg::*;
#(
  parameter int unsigned numInputs     = 784,
  parameter int unsigned numNeurons    = 30,
  parameter int unsigned dataWidth     = 16,
  parameter int unsigned timeoutCycles = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [dataWidth-1:0]            in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [dataWidth-1:0]            nrn_in,
  output logic                            nrn_in_valid,
  input  logic [numNeurons*dataWidth-1:0] nrn_out,
  input  logic [numNeurons-1:0]           nrn_out_valid,
  output logic [dataWidth-1:0]            out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy,
  output logic                            err
);

  localparam int unsigned InCntW = $clog2(numInputs + 1);
  localparam int unsigned IdxW   = IDX_W(numNeurons);
  localparam int unsigned WaitW  = $clog2(timeoutCycles + 1);

  localparam logic [InCntW-1:0] InLast   = InCntW'(numInputs);
  localparam logic [IdxW-1:0]   IdxLast  = IdxW'(numNeurons - 1);
  localparam logic [WaitW-1:0]  WaitLast = WaitW'(timeoutCycles);

  seq_state_t           state_q, state_d;
  logic [InCntW-1:0]    in_cnt_q, in_cnt_d;
  logic [WaitW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [IdxW-1:0]      out_idx_q, out_idx_d;
  logic                 err_q, err_d;
  logic [dataWidth-1:0] nrn_in_q;
  logic                 nrn_in_valid_q;

  logic                  ready_st;
  logic                  accept;
  logic                  clr;
  logic                  rd_en;
  logic                  all_done;
  logic [numNeurons-1:0] cap_we;

  // Gated by rst so in_ready is low for the whole reset interval.
  assign in_ready = ready_st & ~rst;
  assign accept   = in_valid & in_ready;
  assign cap_we   = nrn_out_valid & {numNeurons{state_q == WAIT}};

  always_comb begin
    state_d    = state_q;
    in_cnt_d   = in_cnt_q;
    wait_cnt_d = wait_cnt_q;
    out_idx_d  = out_idx_q;
    err_d      = 1'b0;
    clr        = 1'b0;
    rd_en      = 1'b0;
    ready_st   = 1'b0;
    out_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_st = 1'b1;
        if (accept) begin
          in_cnt_d   = InCntW'(1);
          wait_cnt_d = '0;
          state_d    = (InCntW'(1) == InLast) ? WAIT : FEED;
        end
      end
      FEED: begin
        ready_st = 1'b1;
        if (accept) begin
          in_cnt_d = in_cnt_q + InCntW'(1);
          if (in_cnt_d == InLast) begin
            state_d    = WAIT;
            wait_cnt_d = '0;
          end
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q + WaitW'(1);
        if (all_done) begin
          state_d   = DRAIN;
          out_idx_d = '0;
          rd_en     = 1'b1;
        end else if (wait_cnt_d == WaitLast) begin
          err_d    = 1'b1;
          clr      = 1'b1;
          in_cnt_d = '0;
          state_d  = IDLE;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (out_idx_q == IdxLast) begin
            clr      = 1'b1;
            in_cnt_d = '0;
            state_d  = IDLE;
          end else begin
            out_idx_d = out_idx_q + IdxW'(1);
            rd_en     = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      in_cnt_q       <= '0;
      wait_cnt_q     <= '0;
      out_idx_q      <= '0;
      err_q          <= 1'b0;
      nrn_in_q       <= '0;
      nrn_in_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      in_cnt_q       <= in_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      out_idx_q      <= out_idx_d;
      err_q          <= err_d;
      nrn_in_valid_q <= accept;
      if (accept) nrn_in_q <= in_data;
    end
  end

  assign nrn_in       = nrn_in_q;
  assign nrn_in_valid = nrn_in_valid_q;
  assign busy         = (state_q != IDLE);
  assign err          = err_q;

  fc_result_bank #(
    .numNeurons (numNeurons),
    .dataWidth  (dataWidth)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .we       (cap_we),
    .wdata    (nrn_out),
    .clr      (clr),
    .rd_en    (rd_en),
    .rd_idx   (out_idx_d),
    .rd_data  (out_data),
    .all_done (all_done)
  );

endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed bench for fc_layer_seq with 4 inputs, 3 neurons, 16-bit data, timeout 8.
module tb_fc_layer_seq;

  localparam int unsigned NumIn  = 4;
  localparam int unsigned NumNrn = 3;
  localparam int unsigned DW     = 16;
  localparam int unsigned TmO    = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   nrn_in;
  logic            nrn_in_valid;
  logic [NumNrn*DW-1:0] nrn_out;
  logic [NumNrn-1:0]    nrn_out_valid;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fc_layer_seq #(
    .numInputs     (NumIn),
    .numNeurons    (NumNrn),
    .dataWidth     (DW),
    .timeoutCycles (TmO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .nrn_in        (nrn_in),
    .nrn_in_valid  (nrn_in_valid),
    .nrn_out       (nrn_out),
    .nrn_out_valid (nrn_out_valid),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .err           (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [2:0] m, input logic [15:0] v0, input logic [15:0] v1,
                       input logic [15:0] v2);
    nrn_out_valid = m;
    nrn_out       = {v2, v1, v0};
  endtask

  // Feeds four elements back to back; returns in the first WAIT cycle.
  task automatic feed_vec(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                          input logic [15:0] d);
    logic [15:0] v [4];
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = v[i];
      next();
    end
    in_valid = 1'b0;
  endtask

  // Expects three drain cycles with out_ready high, then idle.
  task automatic drain3(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                        input logic [15:0] e2);
    logic [15:0] e [3];
    e = '{e0, e1, e2};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_data"}, {16'd0, out_data}, {16'd0, e[i]});
      next();
    end
    @(negedge clk);
    check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  logic [15:0] fv [4];

  initial begin
    rst           = 1'b1;
    in_data       = '0;
    in_valid      = 1'b0;
    nrn_out       = '0;
    nrn_out_valid = '0;
    out_ready     = 1'b0;
    fv            = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_nrn_in", {16'd0, nrn_in}, 32'd0);
    check("rst_nrn_in_valid", {31'd0, nrn_in_valid}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    next();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    next();

    // Continuous feed, then staggered capture and drain
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = fv[i];
      @(negedge clk);
      check("feed_in_ready", {31'd0, in_ready}, 32'd1);
      if (i > 0) begin
        check("feed_nrn_in", {16'd0, nrn_in}, {16'd0, fv[i-1]});
        check("feed_nrn_in_valid", {31'd0, nrn_in_valid}, 32'd1);
      end
      next();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    pulse(3'b001, 16'h0011, 16'hBEEF, 16'hBEEF);
    @(negedge clk);
    check("feed_last_nrn_in", {16'd0, nrn_in}, 32'h0400);
    check("feed_last_valid", {31'd0, nrn_in_valid}, 32'd1);
    check("wait_in_ready", {31'd0, in_ready}, 32'd0);
    check("wait_busy", {31'd0, busy}, 32'd1);
    next();
    pulse(3'b000, 16'hBEEF, 16'hBEEF, 16'hBEEF);
    @(negedge clk);
    check("wait1_nrn_in_valid", {31'd0, nrn_in_valid}, 32'd0);
    check("wait1_out_valid", {31'd0, out_valid}, 32'd0);
    next();
    pulse(3'b110, 16'hBEEF, 16'h0022, 16'h0033);
    @(negedge clk);
    check("wait2_out_valid", {31'd0, out_valid}, 32'd0);
    next();
    nrn_out_valid = '0;
    drain3("stagger", 16'h0011, 16'h0022, 16'h0033);
    next();

    // Backpressure
    out_ready = 1'b0;
    feed_vec(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    pulse(3'b111, 16'h0011, 16'h0022, 16'h0033);
    @(negedge clk);
    check("bp_wait_out_valid", {31'd0, out_valid}, 32'd0);
    next();
    nrn_out_valid = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_data", {16'd0, out_data}, 32'h0011);
      next();
    end
    out_ready = 1'b1;
    drain3("bp", 16'h0011, 16'h0022, 16'h0033);
    next();

    // Timeout with only two results
    feed_vec(16'h0005, 16'h0006, 16'h0007, 16'h0008);
    pulse(3'b011, 16'h0AAA, 16'h0BBB, 16'h0CCC);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("to_wait_err", {31'd0, err}, 32'd0);
      check("to_wait_out_valid", {31'd0, out_valid}, 32'd0);
      check("to_wait_busy", {31'd0, busy}, 32'd1);
      next();
      nrn_out_valid = '0;
    end
    @(negedge clk);
    check("to_err", {31'd0, err}, 32'd1);
    check("to_busy", {31'd0, busy}, 32'd0);
    check("to_in_ready", {31'd0, in_ready}, 32'd1);
    check("to_out_valid", {31'd0, out_valid}, 32'd0);
    next();
    @(negedge clk);
    check("to_err_drop", {31'd0, err}, 32'd0);
    next();

    // Vector after timeout: stale captures must not count
    feed_vec(16'h0009, 16'h000A, 16'h000B, 16'h000C);
    pulse(3'b100, 16'hBEEF, 16'hBEEF, 16'h0066);
    @(negedge clk);
    check("after_to_w0_valid", {31'd0, out_valid}, 32'd0);
    next();
    nrn_out_valid = '0;
    @(negedge clk);
    check("after_to_w1_valid", {31'd0, out_valid}, 32'd0);
    next();
    pulse(3'b011, 16'h0044, 16'h0055, 16'hBEEF);
    @(negedge clk);
    check("after_to_w2_valid", {31'd0, out_valid}, 32'd0);
    next();
    nrn_out_valid = '0;
    drain3("after_to", 16'h0044, 16'h0055, 16'h0066);
    next();

    // Stray pulse during FEED
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = fv[i];
      if (i == 1) pulse(3'b111, 16'hDEAD, 16'hDEAD, 16'hDEAD);
      else nrn_out_valid = '0;
      next();
    end
    in_valid      = 1'b0;
    nrn_out_valid = '0;
    @(negedge clk);
    check("stray_w0_valid", {31'd0, out_valid}, 32'd0);
    next();
    @(negedge clk);
    check("stray_w1_valid", {31'd0, out_valid}, 32'd0);
    check("stray_w1_busy", {31'd0, busy}, 32'd1);
    next();
    pulse(3'b111, 16'h0077, 16'h0088, 16'h0099);
    next();
    nrn_out_valid = '0;
    drain3("stray", 16'h0077, 16'h0088, 16'h0099);
    next();

    // Reset after two inputs
    in_valid = 1'b1;
    in_data  = 16'h1111;
    next();
    in_data = 16'h2222;
    next();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_nrn_in_valid", {31'd0, nrn_in_valid}, 32'd0);
    next();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = fv[i];
      @(negedge clk);
      check("midrst_refeed_ready", {31'd0, in_ready}, 32'd1);
      next();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_wait_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_wait_busy", {31'd0, busy}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fc_layer_seq.md
# fc_layer_seq

Sequencer for one fully-connected layer of `Neuron_*` instances. It accepts the layer's input vector one element at a time from the previous stage and broadcasts each element to every neuron in the layer. It then collects the per-neuron results as they become valid and streams them to the next layer over a valid/ready handshake. It sits between a layer's neuron array and the inter-layer buffer, and owns the per-layer "feed, wait, drain" schedule.

## Interface
Parameters:
- `numInputs`, 784: input elements per inference, equal to the neurons' `numWeight`.
- `numNeurons`, 30: neurons in the layer.
- `dataWidth`, 16: element width.
- `timeoutCycles`, 64: maximum WAIT duration before the error exit.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_data`  in  dataWidth: input element from the previous stage.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: sequencer accepts an input this cycle.
- `nrn_in`  out  dataWidth: broadcast to every neuron's `myinput`.
- `nrn_in_valid`  out  1: broadcast to every neuron's `myinputValid`.
- `nrn_out`  in  numNeurons*dataWidth: neuron `out` buses, with neuron k at bits `[k*dataWidth +: dataWidth]`.
- `nrn_out_valid`  in  numNeurons: per-neuron `outvalid` pulses.
- `out_data`  out  dataWidth: result element to the next layer.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: next stage accepts.
- `busy`  out  1: high in any state except IDLE.
- `err`  out  1: one-cycle pulse on timeout.

## Operation
States: IDLE, FEED, WAIT, DRAIN. All state lives in flops reset asynchronously by `rst`.

- **IDLE**
  - `in_ready`=1.
  - On `in_valid & in_ready`, go to FEED, set `in_cnt`=1 and forward the element.
- **FEED**
  - `in_ready`=1.
  - Each accepted element is registered to `nrn_in`, with `nrn_in_valid`=1 on the next cycle. Gaps in `in_valid` produce gaps in `nrn_in_valid`.
  - `in_cnt` increments per accept.
  - When the accept that makes `in_cnt`==`numInputs` occurs, go to WAIT; `in_ready`=0 from the next cycle.
- **WAIT**
  - `in_ready`=0.
  - For each k, `nrn_out_valid[k]` sets `cap_mask[k]` and loads `cap[k]` from `nrn_out` slice k. Pulses for different neurons may arrive on different cycles.
  - A repeated pulse for an already-captured k overwrites `cap[k]`.
  - When `cap_mask` is all ones (including pulses on the current cycle), go to DRAIN with `out_idx`=0.
  - `wait_cnt` increments every WAIT cycle. On reaching `timeoutCycles`: pulse `err`, clear `cap_mask`, go to IDLE.
- **DRAIN**
  - `out_valid`=1 and `out_data`=`cap[out_idx]`.
  - On `out_valid & out_ready`, `out_idx` increments.
  - The handshake at `out_idx`==`numNeurons`-1 returns to IDLE, clears `cap_mask` and `in_cnt`, and drops `out_valid` the next cycle.
  - `out_data` is held stable while `out_valid & !out_ready`.
- `nrn_out_valid` pulses outside WAIT are ignored.
- Counter widths:
  - `in_cnt`: `$clog2(numInputs+1)`.
  - `out_idx`: `$clog2(numNeurons)`, with a minimum of 1.
  - `wait_cnt`: `$clog2(timeoutCycles+1)`.
  - No wrap is reachable.

## Timing
- Reset values: `in_ready`=0 while `rst` is asserted and 1 in the first cycle after release. All other outputs are 0: `nrn_in`=0, `nrn_in_valid`=0, `out_valid`=0, `out_data`=0, `busy`=0, `err`=0. Also state=IDLE and all counters and masks are 0.
- Input-to-broadcast latency is exactly 1 cycle, and there is no backpressure from the neurons.
- The first `out_valid` asserts 1 cycle after the cycle in which the last `nrn_out_valid` bit arrives.
- Drain throughput is one element per cycle when `out_ready` is held high.
- No input is accepted during WAIT or DRAIN, so a new vector may start the cycle after returning to IDLE.
- `rst` asserted mid-FEED, WAIT or DRAIN aborts immediately. Partial captures are discarded and neurons must also be reset by the same `rst`.
- Timeout exit: `err` is high for exactly 1 cycle, coincident with the first IDLE cycle.

## Structure
- Package `fc_layer_pkg`: the `seq_state_t` enum {IDLE, FEED, WAIT, DRAIN} and the `IDX_W(n)` width helper. It is shared with later layer-level controllers.
- Sub-module `fc_result_bank`: `numNeurons` × `dataWidth` capture registers with per-entry write enables, the `cap_mask` logic and the `all_done` output. It has a registered read mux indexed by `out_idx`.
- The FSM, counters and handshake logic stay in `fc_layer_seq`.

## Test plan
Bench settings: `numInputs`=4, `numNeurons`=3, `dataWidth`=16, `timeoutCycles`=8 unless noted.

- **Reset**: check all outputs 0 during `rst`. Deassert `rst` → `in_ready`=1, `busy`=0.
- **Continuous feed**: feed 0x0100, 0x0200, 0x0300, 0x0400 back-to-back → `nrn_in` shows the same values 1 cycle later with `nrn_in_valid`=1 for 4 cycles; `in_ready`=0 after the 4th accept.
- **Staggered capture and drain**:
  - Pulse `nrn_out_valid` = 3'b001 (0x0011), then 3'b110 two cycles later (0x0022, 0x0033).
  - With `out_ready`=1 → `out_data` 0x0011, 0x0022, 0x0033 on 3 consecutive cycles, then IDLE.
- **Backpressure**: hold `out_ready`=0 for 5 cycles in DRAIN → `out_data` stays 0x0011 with `out_valid` high. Release → remaining order unchanged.
- **Timeout**: only 3'b011 arrives → `err` pulses 8 cycles after entering WAIT, state returns to IDLE, and `out_valid` never rises. A following vector completes normally.
- **Stray pulses and mid-operation reset**:
  - A `nrn_out_valid` pulse during FEED has no effect.
  - `rst` after 2 of 4 inputs → next vector needs all 4 inputs to reach WAIT.
